// File: rtl/seg7_display.sv
// rtl/seg7_display.sv - bus-writable eight-digit multiplexed seven-segment display driver
module seg7_display #(
    parameter int SCAN_DIV = 50000
) (
    input  logic        CLK_I,
    input  logic        RST_I,
    input  logic        CYC_I,
    input  logic        STB_I,
    input  logic        WE_I,
    input  logic        ADR_I,
    input  logic [31:0] DAT_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic [7:0]  seg,
    output logic [7:0]  an
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);

    logic [31:0]   data_q, data_d;
    logic [16:0]   ctrl_q, ctrl_d;
    logic          ack_q, ack_d;
    logic [31:0]   dat_q, dat_d;
    logic [PW-1:0] presc_q, presc_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    seg_q, seg_d;
    logic [7:0]    an_q, an_d;

    logic [3:0]    nib;
    logic [7:0]    dp_mask;
    logic [7:0]    blank_mask;
    logic          enable;

    // Active-low g..a patterns for one hex nibble.
    function automatic logic [6:0] decode(input logic [3:0] v);
        logic [6:0] r;
        case (v)
            4'h0: r = 7'h40;
            4'h1: r = 7'h79;
            4'h2: r = 7'h24;
            4'h3: r = 7'h30;
            4'h4: r = 7'h19;
            4'h5: r = 7'h12;
            4'h6: r = 7'h02;
            4'h7: r = 7'h78;
            4'h8: r = 7'h00;
            4'h9: r = 7'h10;
            4'hA: r = 7'h08;
            4'hB: r = 7'h03;
            4'hC: r = 7'h46;
            4'hD: r = 7'h21;
            4'hE: r = 7'h06;
            default: r = 7'h0E;
        endcase
        return r;
    endfunction

    assign dp_mask    = ctrl_q[7:0];
    assign blank_mask = ctrl_q[15:8];
    assign enable     = ctrl_q[16];
    assign nib        = data_q[{idx_q, 2'b00} +: 4];

    always_comb begin
        ack_d   = CYC_I & STB_I & ~ack_q;
        data_d  = data_q;
        ctrl_d  = ctrl_q;
        dat_d   = dat_q;
        presc_d = '0;
        idx_d   = '0;
        an_d    = 8'hFF;
        seg_d   = 8'hFF;

        // Register access happens only on the edge that raises ACK.
        if (ack_d) begin
            if (WE_I) begin
                if (ADR_I) begin
                    ctrl_d = DAT_I[16:0];
                end else begin
                    data_d = DAT_I;
                end
            end else begin
                dat_d = ADR_I ? {15'd0, ctrl_q} : data_q;
            end
        end

        if (enable) begin
            if (presc_q == PRESC_LAST) begin
                presc_d = '0;
                idx_d   = idx_q + 3'd1;
            end else begin
                presc_d = presc_q + 1'b1;
                idx_d   = idx_q;
            end
        end

        // Display stage works from state registered on the previous edge.
        if (enable) begin
            seg_d = {~dp_mask[idx_q], decode(nib)};
            if (!blank_mask[idx_q]) begin
                an_d = ~(8'd1 << idx_q);
            end
        end
    end

    always_ff @(posedge CLK_I) begin
        if (RST_I) begin
            data_q  <= '0;
            ctrl_q  <= 17'h1_0000;
            ack_q   <= 1'b0;
            dat_q   <= '0;
            presc_q <= '0;
            idx_q   <= '0;
            seg_q   <= 8'hFF;
            an_q    <= 8'hFF;
        end else begin
            data_q  <= data_d;
            ctrl_q  <= ctrl_d;
            ack_q   <= ack_d;
            dat_q   <= dat_d;
            presc_q <= presc_d;
            idx_q   <= idx_d;
            seg_q   <= seg_d;
            an_q    <= an_d;
        end
    end

    assign DAT_O = dat_q;
    assign ACK_O = ack_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_seg7_display.sv
// tb/tb_seg7_display.sv - directed scoreboard bench for seg7_display
module tb_seg7_display;

    localparam int DIV = 4;
    localparam logic [31:0] D = 32'h89AB_CDEF;

    logic        CLK_I = 1'b0;
    logic        RST_I, CYC_I, STB_I, WE_I, ADR_I;
    logic [31:0] DAT_I, DAT_O;
    logic        ACK_O;
    logic [7:0]  seg, an;

    int errors = 0;
    int checks = 0;

    logic [15:0] disp_q[$];
    logic [31:0] rd_q[$];

    seg7_display #(.SCAN_DIV(DIV)) dut (
        .CLK_I(CLK_I), .RST_I(RST_I), .CYC_I(CYC_I), .STB_I(STB_I),
        .WE_I(WE_I), .ADR_I(ADR_I), .DAT_I(DAT_I), .DAT_O(DAT_O),
        .ACK_O(ACK_O), .seg(seg), .an(an)
    );

    always #5 CLK_I = ~CLK_I;

    function automatic logic [6:0] seg_lut(input logic [3:0] v);
        logic [6:0] t [16];
        t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[v];
    endfunction

    // Expected {an, seg} for digit d given DATA/CTRL contents.
    function automatic logic [15:0] dexp(input int d, input logic [31:0] data, input logic [16:0] ctrl);
        logic [3:0] nib;
        logic [7:0] a;
        logic [7:0] s;
        if (!ctrl[16]) return 16'hFFFF;
        nib = data[4*d +: 4];
        a   = ctrl[8+d] ? 8'hFF : ~(8'h01 << d);
        s   = {~ctrl[d], seg_lut(nib)};
        return {a, s};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge CLK_I);
        #1;
    endtask

    task automatic push_disp(input int first, input int n, input logic [31:0] data, input logic [16:0] ctrl);
        for (int k = first; k < first + n; k++) disp_q.push_back(dexp((k / DIV) % 8, data, ctrl));
    endtask

    task automatic pop_disp(input string tag);
        logic [15:0] e;
        e = (disp_q.size() > 0) ? disp_q.pop_front() : 16'hxxxx;
        chk(tag, {16'd0, an, seg}, {16'd0, e});
    endtask

    task automatic run_disp(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            tick;
            chk({tag, "_ack_low"}, {31'd0, ACK_O}, 32'd0);
            pop_disp(tag);
        end
    endtask

    task automatic bus(input logic we, input logic adr, input logic [31:0] wd, input string tag);
        logic [31:0] e;
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = we; ADR_I = adr; DAT_I = wd;
        tick;
        chk({tag, "_ack"}, {31'd0, ACK_O}, 32'd1);
        if (!we) begin
            e = (rd_q.size() > 0) ? rd_q.pop_front() : 32'hxxxx_xxxx;
            chk({tag, "_rdata"}, DAT_O, e);
        end
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
    endtask

    task automatic idle(input string tag);
        tick;
        chk({tag, "_ack_low"}, {31'd0, ACK_O}, 32'd0);
    endtask

    initial begin
        RST_I = 1'b1; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0; ADR_I = 1'b0; DAT_I = '0;

        // Reset and idle scan
        tick; tick;
        chk("rst_an", {24'd0, an}, 32'hFF);
        chk("rst_seg", {24'd0, seg}, 32'hFF);
        chk("rst_ack", {31'd0, ACK_O}, 32'd0);
        chk("rst_dat", DAT_O, 32'd0);
        RST_I = 1'b0;
        push_disp(0, 33, 32'd0, 17'h1_0000);
        run_disp(33, "scan_idle");

        // DATA write and readback
        bus(1'b1, 1'b0, D, "wr_data");
        idle("wr_data");
        rd_q.push_back(D);
        bus(1'b0, 1'b0, 32'd0, "rd_data");
        idle("rd_data");
        rd_q.push_back(32'h0001_0000);
        bus(1'b0, 1'b1, 32'd0, "rd_ctrl");
        idle("rd_ctrl");
        bus(1'b1, 1'b1, 32'd0, "dis");
        idle("dis");
        bus(1'b1, 1'b1, 32'h0001_0000, "en");
        push_disp(0, 32, D, 17'h1_0000);
        run_disp(32, "digits");

        // Blank and dp masks
        bus(1'b1, 1'b1, 32'd0, "dis2");
        idle("dis2");
        bus(1'b1, 1'b1, 32'hFFFF_0F01, "wr_ctrl");
        push_disp(0, 32, D, 17'h1_0F01);
        run_disp(32, "blank");
        rd_q.push_back(32'h0001_0F01);
        bus(1'b0, 1'b1, 32'd0, "rd_ctrl2");
        idle("rd_ctrl2");

        // Disable mid-frame while digit 5 is lit, then re-enable
        bus(1'b1, 1'b1, 32'd0, "dis3");
        idle("dis3");
        bus(1'b1, 1'b1, 32'h0001_0000, "en3");
        push_disp(0, 22, D, 17'h1_0000);
        run_disp(22, "pre_dis");
        disp_q.push_back(dexp(5, D, 17'h1_0000));
        bus(1'b1, 1'b1, 32'd0, "dis_mid");
        pop_disp("dis_edge");
        for (int i = 0; i < 4; i++) disp_q.push_back(16'hFFFF);
        run_disp(4, "disabled");
        bus(1'b1, 1'b1, 32'h0001_0000, "reen");
        push_disp(0, 5, D, 17'h1_0000);
        run_disp(5, "reen");

        // Held strobe: alternate ACKs, two writes, one on a scan step
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 1'b0;
        DAT_I = 32'h1111_1111;
        disp_q.push_back(dexp(1, D, 17'h1_0000));
        tick;
        chk("held_ack0", {31'd0, ACK_O}, 32'd1);
        pop_disp("held_d0");
        DAT_I = 32'h2222_2222;
        disp_q.push_back(dexp(1, 32'h1111_1111, 17'h1_0000));
        tick;
        chk("held_ack1", {31'd0, ACK_O}, 32'd0);
        pop_disp("held_d1");
        DAT_I = 32'h3333_3333;
        disp_q.push_back(dexp(1, 32'h1111_1111, 17'h1_0000));
        tick;
        chk("held_ack2", {31'd0, ACK_O}, 32'd1);
        pop_disp("held_d2");
        DAT_I = 32'h4444_4444;
        disp_q.push_back(dexp(2, 32'h3333_3333, 17'h1_0000));
        tick;
        chk("held_ack3", {31'd0, ACK_O}, 32'd0);
        pop_disp("held_d3");
        CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        rd_q.push_back(32'h3333_3333);
        bus(1'b0, 1'b0, 32'd0, "rd_held");
        idle("rd_held");

        // Reset during a strobed write
        CYC_I = 1'b1; STB_I = 1'b1; WE_I = 1'b1; ADR_I = 1'b0; DAT_I = 32'hDEAD_BEEF;
        RST_I = 1'b1;
        tick;
        chk("rstw_ack", {31'd0, ACK_O}, 32'd0);
        chk("rstw_an", {24'd0, an}, 32'hFF);
        chk("rstw_seg", {24'd0, seg}, 32'hFF);
        chk("rstw_dat", DAT_O, 32'd0);
        RST_I = 1'b0; CYC_I = 1'b0; STB_I = 1'b0; WE_I = 1'b0;
        disp_q.push_back(dexp(0, 32'd0, 17'h1_0000));
        run_disp(1, "post_rst");
        rd_q.push_back(32'd0);
        bus(1'b0, 1'b0, 32'd0, "rd_rst_data");
        idle("rd_rst_data");
        rd_q.push_back(32'h0001_0000);
        bus(1'b0, 1'b1, 32'd0, "rd_rst_ctrl");
        idle("rd_rst_ctrl");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
